// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: control path of the 5-stage RV32I core.
// Decodes the ID instruction into a 12-bit control bundle and carries it through
// the ID/EX, EX/MEM and MEM/WB control registers. It also handles load-use stalls,
// redirect flushes and memory holds, and keeps saturating stall/flush counters.
module ctrl_pipe_unit #(
    parameter bit          EXT_EN = 1'b1,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned CTRL_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       if_id_inst,
    input  logic              if_id_valid,
    input  logic              ex_redirect,
    input  logic              mem_hold,
    output logic              stall_o,
    output logic              flush_o,
    output logic              illegal_o,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic [CTRL_W-1:0] ex_mem_ctrl,
    output logic [CTRL_W-1:0] mem_wb_ctrl,
    output logic              id_ex_valid,
    output logic              ex_mem_valid,
    output logic              mem_wb_valid,
    output logic [4:0]        id_ex_rs1,
    output logic [4:0]        id_ex_rs2,
    output logic [4:0]        id_ex_rd,
    output logic [4:0]        ex_mem_rd,
    output logic [4:0]        mem_wb_rd,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Returns {known, bundle}; unknown opcodes give an all-zero bundle.
    function automatic logic [CTRL_W:0] decode(input logic [6:0] op);
        logic [CTRL_W-1:0] c;
        logic              k;
        c = '0;
        k = 1'b1;
        case (op)
            OP_R:     begin c[7] = 1'b1; c[1:0] = 2'b10; end
            OP_LOAD:  begin c[3] = 1'b1; c[4] = 1'b1; c[6] = 1'b1; c[7] = 1'b1; end
            OP_IALU:  begin c[6] = 1'b1; c[7] = 1'b1; c[1:0] = 2'b10; end
            OP_STORE: begin c[5] = 1'b1; c[6] = 1'b1; end
            OP_BR:    begin c[2] = 1'b1; c[1:0] = 2'b01; end
            OP_JAL: begin
                if (EXT_EN) begin c[8] = 1'b1; c[7] = 1'b1; end
                else        k = 1'b0;
            end
            OP_JALR: begin
                if (EXT_EN) begin c[9] = 1'b1; c[6] = 1'b1; c[7] = 1'b1; end
                else        k = 1'b0;
            end
            OP_LUI: begin
                if (EXT_EN) begin c[10] = 1'b1; c[6] = 1'b1; c[7] = 1'b1; end
                else        k = 1'b0;
            end
            OP_AUIPC: begin
                if (EXT_EN) begin c[11] = 1'b1; c[6] = 1'b1; c[7] = 1'b1; end
                else        k = 1'b0;
            end
            default: k = 1'b0;
        endcase
        return {k, c};
    endfunction

    // Saturating increment: parks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        else    return v + CNT_W'(1);
    endfunction

    logic [CTRL_W-1:0] id_ex_ctrl_q, id_ex_ctrl_d;
    logic [CTRL_W-1:0] ex_mem_ctrl_q, ex_mem_ctrl_d;
    logic [CTRL_W-1:0] mem_wb_ctrl_q, mem_wb_ctrl_d;
    logic              id_ex_valid_q, id_ex_valid_d;
    logic              ex_mem_valid_q, ex_mem_valid_d;
    logic              mem_wb_valid_q, mem_wb_valid_d;
    logic [4:0]        id_ex_rs1_q, id_ex_rs1_d;
    logic [4:0]        id_ex_rs2_q, id_ex_rs2_d;
    logic [4:0]        id_ex_rd_q, id_ex_rd_d;
    logic [4:0]        ex_mem_rd_q, ex_mem_rd_d;
    logic [4:0]        mem_wb_rd_q, mem_wb_rd_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [CTRL_W:0]   dec_s;
    logic [CTRL_W-1:0] dec_ctrl_s;
    logic              known_s;
    logic [6:0]        opcode_s;
    logic [4:0]        rs1_s, rs2_s, rd_s;
    logic              rs1_used_s, rs2_used_s;
    logic              hazard_s;
    logic              unused_s;

    assign opcode_s   = if_id_inst[6:0];
    assign rd_s       = if_id_inst[11:7];
    assign rs1_s      = if_id_inst[19:15];
    assign rs2_s      = if_id_inst[24:20];
    assign dec_s      = decode(opcode_s);
    assign known_s    = dec_s[CTRL_W];
    assign dec_ctrl_s = if_id_valid ? dec_s[CTRL_W-1:0] : '0;
    assign unused_s   = ^{if_id_inst[31:25], if_id_inst[14:12]};

    // Which source registers the ID instruction actually reads.
    always_comb begin
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
        case (opcode_s)
            OP_R, OP_STORE, OP_BR: begin rs1_used_s = 1'b1; rs2_used_s = 1'b1; end
            OP_LOAD, OP_IALU:      rs1_used_s = 1'b1;
            OP_JALR:               rs1_used_s = EXT_EN;
            default:               begin rs1_used_s = 1'b0; rs2_used_s = 1'b0; end
        endcase
    end

    assign hazard_s = if_id_valid & id_ex_valid_q & id_ex_ctrl_q[3] & (id_ex_rd_q != 5'd0) &
                      ((rs1_used_s & (rs1_s == id_ex_rd_q)) |
                       (rs2_used_s & (rs2_s == id_ex_rd_q)));

    assign illegal_o = if_id_valid & ~known_s;
    assign flush_o   = ex_redirect & ~mem_hold;
    assign stall_o   = mem_hold | (~ex_redirect & hazard_s);

    // Next-state selection: hold > redirect bubble > hazard bubble > normal issue.
    always_comb begin
        id_ex_ctrl_d   = id_ex_ctrl_q;
        id_ex_valid_d  = id_ex_valid_q;
        id_ex_rs1_d    = id_ex_rs1_q;
        id_ex_rs2_d    = id_ex_rs2_q;
        id_ex_rd_d     = id_ex_rd_q;
        ex_mem_ctrl_d  = ex_mem_ctrl_q;
        ex_mem_valid_d = ex_mem_valid_q;
        ex_mem_rd_d    = ex_mem_rd_q;
        mem_wb_ctrl_d  = mem_wb_ctrl_q;
        mem_wb_valid_d = mem_wb_valid_q;
        mem_wb_rd_d    = mem_wb_rd_q;
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        if (!mem_hold) begin
            ex_mem_ctrl_d  = id_ex_ctrl_q;
            ex_mem_valid_d = id_ex_valid_q;
            ex_mem_rd_d    = id_ex_rd_q;
            mem_wb_ctrl_d  = ex_mem_ctrl_q;
            mem_wb_valid_d = ex_mem_valid_q;
            mem_wb_rd_d    = ex_mem_rd_q;
            if (ex_redirect || hazard_s) begin
                id_ex_ctrl_d  = '0;
                id_ex_valid_d = 1'b0;
                id_ex_rs1_d   = 5'd0;
                id_ex_rs2_d   = 5'd0;
                id_ex_rd_d    = 5'd0;
                if (ex_redirect) flush_cnt_d = sat_inc(flush_cnt_q);
                else             stall_cnt_d = sat_inc(stall_cnt_q);
            end else begin
                id_ex_ctrl_d  = dec_ctrl_s;
                id_ex_valid_d = if_id_valid;
                id_ex_rs1_d   = rs1_s;
                id_ex_rs2_d   = rs2_s;
                id_ex_rd_d    = rd_s;
            end
        end else begin
            stall_cnt_d = stall_cnt_q;
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Pipeline control registers and counters with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_ex_ctrl_q   <= '0;
            ex_mem_ctrl_q  <= '0;
            mem_wb_ctrl_q  <= '0;
            id_ex_valid_q  <= 1'b0;
            ex_mem_valid_q <= 1'b0;
            mem_wb_valid_q <= 1'b0;
            id_ex_rs1_q    <= 5'd0;
            id_ex_rs2_q    <= 5'd0;
            id_ex_rd_q     <= 5'd0;
            ex_mem_rd_q    <= 5'd0;
            mem_wb_rd_q    <= 5'd0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
        end else begin
            id_ex_ctrl_q   <= id_ex_ctrl_d;
            ex_mem_ctrl_q  <= ex_mem_ctrl_d;
            mem_wb_ctrl_q  <= mem_wb_ctrl_d;
            id_ex_valid_q  <= id_ex_valid_d;
            ex_mem_valid_q <= ex_mem_valid_d;
            mem_wb_valid_q <= mem_wb_valid_d;
            id_ex_rs1_q    <= id_ex_rs1_d;
            id_ex_rs2_q    <= id_ex_rs2_d;
            id_ex_rd_q     <= id_ex_rd_d;
            ex_mem_rd_q    <= ex_mem_rd_d;
            mem_wb_rd_q    <= mem_wb_rd_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign id_ex_ctrl   = id_ex_ctrl_q;
    assign ex_mem_ctrl  = ex_mem_ctrl_q;
    assign mem_wb_ctrl  = mem_wb_ctrl_q;
    assign id_ex_valid  = id_ex_valid_q;
    assign ex_mem_valid = ex_mem_valid_q;
    assign mem_wb_valid = mem_wb_valid_q;
    assign id_ex_rs1    = id_ex_rs1_q;
    assign id_ex_rs2    = id_ex_rs2_q;
    assign id_ex_rd     = id_ex_rd_q;
    assign ex_mem_rd    = ex_mem_rd_q;
    assign mem_wb_rd    = mem_wb_rd_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: one instance with extensions and 16-bit
// counters, one without extensions and 2-bit counters, both fed the same stream.
module tb_ctrl_pipe_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic        valid;
    logic        redir;
    logic        hold;

    logic        stall_a, flush_a, ill_a;
    logic [11:0] idex_c_a, exmem_c_a, memwb_c_a;
    logic        idex_v_a, exmem_v_a, memwb_v_a;
    logic [4:0]  rs1_a, rs2_a, idex_rd_a, exmem_rd_a, memwb_rd_a;
    logic [15:0] scnt_a, fcnt_a;

    logic        stall_b, flush_b, ill_b;
    logic [11:0] idex_c_b, exmem_c_b, memwb_c_b;
    logic        idex_v_b, exmem_v_b, memwb_v_b;
    logic [4:0]  rs1_b, rs2_b, idex_rd_b, exmem_rd_b, memwb_rd_b;
    logic [1:0]  scnt_b, fcnt_b;

    int total;
    int bad;

    localparam logic [31:0] ADD3   = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] LW5    = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] ADD6   = 32'h00028333; // add x6,x5,x0
    localparam logic [31:0] LW0    = 32'h0000A003; // lw x0,0(x1)
    localparam logic [31:0] ADD600 = 32'h00000333; // add x6,x0,x0
    localparam logic [31:0] JAL1   = 32'h008000EF; // jal x1,8

    ctrl_pipe_unit #(.EXT_EN(1'b1), .CNT_W(16), .CTRL_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .if_id_inst(inst), .if_id_valid(valid),
        .ex_redirect(redir), .mem_hold(hold),
        .stall_o(stall_a), .flush_o(flush_a), .illegal_o(ill_a),
        .id_ex_ctrl(idex_c_a), .ex_mem_ctrl(exmem_c_a), .mem_wb_ctrl(memwb_c_a),
        .id_ex_valid(idex_v_a), .ex_mem_valid(exmem_v_a), .mem_wb_valid(memwb_v_a),
        .id_ex_rs1(rs1_a), .id_ex_rs2(rs2_a),
        .id_ex_rd(idex_rd_a), .ex_mem_rd(exmem_rd_a), .mem_wb_rd(memwb_rd_a),
        .stall_cnt(scnt_a), .flush_cnt(fcnt_a)
    );

    ctrl_pipe_unit #(.EXT_EN(1'b0), .CNT_W(2), .CTRL_W(12)) dut0 (
        .clk(clk), .rst_n(rst_n), .if_id_inst(inst), .if_id_valid(valid),
        .ex_redirect(redir), .mem_hold(hold),
        .stall_o(stall_b), .flush_o(flush_b), .illegal_o(ill_b),
        .id_ex_ctrl(idex_c_b), .ex_mem_ctrl(exmem_c_b), .mem_wb_ctrl(memwb_c_b),
        .id_ex_valid(idex_v_b), .ex_mem_valid(exmem_v_b), .mem_wb_valid(memwb_v_b),
        .id_ex_rs1(rs1_b), .id_ex_rs2(rs2_b),
        .id_ex_rd(idex_rd_b), .ex_mem_rd(exmem_rd_b), .mem_wb_rd(memwb_rd_b),
        .stall_cnt(scnt_b), .flush_cnt(fcnt_b)
    );

    // Free-running core clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present ID-stage inputs, then let combinational outputs settle.
    task automatic drive(input logic [31:0] i, input logic v, input logic r, input logic h);
        inst  = i;
        valid = v;
        redir = r;
        hold  = h;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive($urandom(), 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk_val("rst_idex_ctrl", idex_c_a, 32'h0);
        chk_val("rst_exmem_ctrl", exmem_c_a, 32'h0);
        chk_val("rst_memwb_ctrl", memwb_c_a, 32'h0);
        chk_val("rst_valids", {idex_v_a, exmem_v_a, memwb_v_a}, 32'h0);
        chk_val("rst_rds", {idex_rd_a, exmem_rd_a, memwb_rd_a, rs1_a, rs2_a}, 32'h0);
        chk_val("rst_cnts", {scnt_a, fcnt_a}, 32'h0);
        rst_n = 1'b1;

        // R-type walks the pipe with 1/2/3 cycle latency.
        drive(ADD3, 1'b1, 1'b0, 1'b0);
        chk_val("add_stall", stall_a, 32'h0);
        chk_val("add_illegal", ill_a, 32'h0);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        chk_val("add_idex_ctrl", idex_c_a, 32'h082);
        chk_val("add_idex_regs", {idex_rd_a, rs1_a, rs2_a, idex_v_a}, {16'h0, 5'd3, 5'd1, 5'd2, 1'b1});
        tick();
        chk_val("add_exmem_ctrl", exmem_c_a, 32'h082);
        chk_val("add_exmem_rd", exmem_rd_a, 32'd3);
        chk_val("nop_idex_valid", idex_v_a, 32'h0);
        tick();
        chk_val("add_memwb_ctrl", memwb_c_a, 32'h082);
        chk_val("add_memwb_rd", {memwb_rd_a, memwb_v_a}, {26'h0, 5'd3, 1'b1});

        // Load-use: one stall cycle, bubble, then the add issues.
        drive(LW5, 1'b1, 1'b0, 1'b0);
        tick();
        chk_val("lw_idex_ctrl", idex_c_a, 32'h0D8);
        drive(ADD6, 1'b1, 1'b0, 1'b0);
        chk_val("lu_stall", stall_a, 32'h1);
        chk_val("lu_flush", flush_a, 32'h0);
        tick();
        chk_val("lu_bubble", {idex_c_a, idex_v_a}, 32'h0);
        chk_val("lu_exmem_lw", exmem_c_a, 32'h0D8);
        chk_val("lu_scnt", scnt_a, 32'd1);
        chk_val("lu_scnt_b", scnt_b, 32'd1);
        chk_val("lu_stall_clear", stall_a, 32'h0);
        tick();
        chk_val("lu_add_late", {idex_c_a, idex_rd_a}, {15'h0, 12'h082, 5'd6});

        // Load to x0 never stalls.
        drive(LW0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(ADD600, 1'b1, 1'b0, 1'b0);
        chk_val("x0_stall", stall_a, 32'h0);
        tick();
        chk_val("x0_idex", {idex_v_a, idex_rd_a}, {26'h0, 1'b1, 5'd6});
        chk_val("x0_scnt", scnt_a, 32'd1);

        // Redirect beats a load-use hazard.
        drive(LW5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(ADD6, 1'b1, 1'b1, 1'b0);
        chk_val("rd_flush", flush_a, 32'h1);
        chk_val("rd_stall", stall_a, 32'h0);
        tick();
        chk_val("rd_bubble", {idex_c_a, idex_v_a}, 32'h0);
        chk_val("rd_fcnt", fcnt_a, 32'd1);
        chk_val("rd_scnt", scnt_a, 32'd1);

        // JAL decode with and without extensions.
        drive(JAL1, 1'b1, 1'b0, 1'b0);
        chk_val("jal_ill_ext", ill_a, 32'h0);
        chk_val("jal_ill_noext", ill_b, 32'h1);
        tick();
        chk_val("jal_ctrl_ext", idex_c_a, 32'h180);
        chk_val("jal_ctrl_noext", idex_c_b, 32'h0);

        // Memory hold freezes everything, including a simultaneous redirect.
        drive(LW5, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(ADD6, 1'b1, (k == 1), 1'b1);
            chk_val("hold_stall", stall_a, 32'h1);
            chk_val("hold_flush", flush_a, 32'h0);
            tick();
            chk_val("hold_idex", idex_c_a, 32'h0D8);
            chk_val("hold_exmem", exmem_c_a, 32'h180);
            chk_val("hold_cnts", {scnt_a, fcnt_a}, {16'd1, 16'd1});
        end
        drive(ADD6, 1'b1, 1'b0, 1'b0);
        chk_val("post_hold_stall", stall_a, 32'h1);
        tick();
        chk_val("post_hold_scnt", scnt_a, 32'd2);
        tick();

        // Three more hazards: 5 total, 2-bit counter parks at 3.
        for (int k = 0; k < 3; k++) begin
            drive(LW5, 1'b1, 1'b0, 1'b0);
            tick();
            drive(ADD6, 1'b1, 1'b0, 1'b0);
            tick();
            tick();
        end
        chk_val("sat_scnt_a", scnt_a, 32'd5);
        chk_val("sat_scnt_b", scnt_b, 32'd3);
        chk_val("sat_fcnt_b", fcnt_b, 32'd1);

        // Mid-stream reset clears in-flight state on the next edge.
        drive(ADD3, 1'b1, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        chk_val("mrst_ctrls", {idex_c_a, exmem_c_a, memwb_c_a}, 32'h0);
        chk_val("mrst_cnts", {scnt_a, fcnt_a}, 32'h0);
        chk_val("mrst_valids", {idex_v_a, exmem_v_a, memwb_v_a}, 32'h0);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Parametrised pipelined control unit for the 5-stage RV32I core. It decodes the IF/ID instruction into a packed control bundle, extended with JAL/JALR/LUI/AUIPC, and carries the bundle plus register indices through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards, handles branch/jump redirect flushes and global memory holds, and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- EXT_EN, 1, 1 = decode JAL/JALR/LUI/AUIPC; 0 = treat them as illegal (zero bundle)
- CNT_W, 16, width of performance counters
- CTRL_W, 12, bundle width (fixed map below; not user-changeable)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- if_id_inst  in  32  instruction in ID
- if_id_valid  in  1  ID slot holds a real instruction
- ex_redirect  in  1  branch taken / jump resolved in EX this cycle
- mem_hold  in  1  data memory busy; freeze all stages
- stall_o  out  1  hold PC and IF/ID (combinational)
- flush_o  out  1  clear IF/ID (combinational, = ex_redirect & ~mem_hold)
- illegal_o  out  1  valid ID instruction with undecodable opcode (combinational)
- id_ex_ctrl / ex_mem_ctrl / mem_wb_ctrl  out  CTRL_W  registered bundles
- id_ex_valid / ex_mem_valid / mem_wb_valid  out  1  stage holds a real instruction
- id_ex_rs1, id_ex_rs2  out  5  source indices for forwarding
- id_ex_rd / ex_mem_rd / mem_wb_rd  out  5  destination indices
- stall_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
- Bundle bit map: [1:0] alu_op, 2 branch, 3 mem_read, 4 mem_to_reg, 5 mem_write, 6 alu_src, 7 reg_write, 8 jump, 9 jalr, 10 lui, 11 auipc.
- Decode on inst[6:0]; unlisted bits are 0:
  - 0110011 R: reg_write, alu_op=10.
  - 0000011 load: mem_read, mem_to_reg, alu_src, reg_write, alu_op=00.
  - 0010011 I-ALU: alu_src, reg_write, alu_op=10.
  - 0100011 store: mem_write, alu_src, alu_op=00.
  - 1100011 branch: branch, alu_op=01.
  - With EXT_EN=1 only:
    - 1101111 JAL: jump, reg_write.
    - 1100111 JALR: jalr, alu_src, reg_write, alu_op=00.
    - 0110111 LUI: lui, alu_src, reg_write.
    - 0010111 AUIPC: auipc, alu_src, reg_write.
  - Anything else: all-zero bundle; illegal_o = if_id_valid.
- No X outputs: mem_to_reg is 0 for store and branch.
- Source use:
  - rs1 used by R, load, I-ALU, store, branch, JALR.
  - rs2 used by R, store, branch.
- Load-use hazard = if_id_valid & id_ex_valid & id_ex_ctrl[3] & id_ex_rd≠0 & ((rs1 used & rs1==id_ex_rd) | (rs2 used & rs2==id_ex_rd)).
- Per-cycle priority, highest first:
  1. ~rst_n: all registers and counters cleared.
  2. mem_hold: every register holds its value; stall_o=1, flush_o=0; counters hold.
  3. ex_redirect: ID/EX loads a bubble (ctrl=0, valid=0); EX/MEM and MEM/WB advance; flush_o=1, stall_o=0 even if a hazard is present; flush_cnt increments.
  4. Hazard: ID/EX loads a bubble; later stages advance; stall_o=1; stall_cnt increments.
  5. Otherwise: ID/EX loads the decoded bundle, inst[11:7]/[19:15]/[24:20] and if_id_valid; an invalid ID slot always yields a zero bundle. Later stages advance.
- Advance: EX/MEM ← ID/EX (ctrl, rd, valid); MEM/WB ← EX/MEM.
- Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- Reset value of every output register is 0: ctrl, valid, rd, rs and counters. Combinational outputs follow their inputs immediately after reset.
- Latency: an instruction in ID at edge N appears in id_ex at N+1, ex_mem at N+2, mem_wb at N+3.
- stall_o, flush_o and illegal_o are combinational, valid within the same cycle; no registered handshake.
- A load-use stall lasts exactly one cycle. The next cycle the load has moved to EX/MEM, so the hazard clears.
- mem_hold together with ex_redirect: the hold wins and the redirect must be re-presented by EX, which is itself frozen.
- Reset asserted mid-stream clears all in-flight bundles on the next edge; no partial state survives.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with a random inst → all ctrl/valid/rd/counters are 0; then release.
- R-type add x3,x1,x2 (0x002081B3), valid: id_ex_ctrl=0x082 at +1, ex_mem at +2, mem_wb at +3; rd=3 throughout; stall_o=0.
- Load-use: lw x5,0(x1) followed by add x6,x5,x0 → one stall_o=1 cycle, a bubble in id_ex, add enters id_ex one cycle late; stall_cnt=1. Repeat with rd=x0 → no stall.
- Redirect: assert ex_redirect while a load-use hazard is present → flush_o=1, stall_o=0, id_ex bubble, flush_cnt=1, stall_cnt unchanged.
- EXT_EN=0, JAL 0x008000EF valid → illegal_o=1, zero bundle. EXT_EN=1, same instruction → ctrl=0x180, illegal_o=0.
- mem_hold high for 3 cycles mid-stream → all stage registers and counters frozen, stall_o=1. With CNT_W=2 and 5 hazards, stall_cnt saturates at 3.
